// File: rtl/csa_accumulator.sv
// Streaming carry-save accumulator: folds one operand per beat into a redundant (sum, carry) pair.
// Optional operand counter enabled by defining CSA_ACC_COUNT_EN.
module csa_accumulator #(
    parameter int BITS = 40
`ifdef CSA_ACC_COUNT_EN
    ,
    parameter int COUNT_W = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_sum,
    output logic [BITS-1:0] out_carry
`ifdef CSA_ACC_COUNT_EN
    ,
    output logic [COUNT_W-1:0] out_count
`endif
);

    logic [BITS-1:0] acc_s;
    logic [BITS-1:0] acc_c;
    logic [BITS-1:0] o_s;
    logic [BITS-1:0] o_c;
    logic [BITS-1:0] nxt_s;
    logic [BITS-1:0] nxt_c;
    logic [BITS-1:0] maj;
    logic            accept;

    // A held result blocks every beat, last or not, so the accumulator freezes too.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // 3:2 compression; the MSB carry-out falls off, giving modulo 2^BITS.
    assign nxt_s = acc_s ^ acc_c ^ in_data;
    assign maj   = (acc_s & acc_c) | (acc_s & in_data) | (acc_c & in_data);
    assign nxt_c = {maj[BITS-2:0], 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s     <= '0;
            acc_c     <= '0;
            o_s       <= '0;
            o_c       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    o_s       <= nxt_s;
                    o_c       <= nxt_c;
                    acc_s     <= '0;
                    acc_c     <= '0;
                    out_valid <= 1'b1;
                end else begin
                    acc_s <= nxt_s;
                    acc_c <= nxt_c;
                end
            end
        end
    end

    assign out_sum   = o_s;
    assign out_carry = o_c;

`ifdef CSA_ACC_COUNT_EN
    logic [COUNT_W-1:0] acc_n;
    logic [COUNT_W-1:0] o_n;
    logic [COUNT_W-1:0] acc_n_inc;

    // Saturate at all-ones instead of wrapping.
    assign acc_n_inc = (acc_n == '1) ? acc_n : acc_n + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_n <= '0;
            o_n   <= '0;
        end else if (accept) begin
            if (in_last) begin
                o_n   <= acc_n_inc;
                acc_n <= '0;
            end else begin
                acc_n <= acc_n_inc;
            end
        end
    end

    assign out_count = o_n;
`endif

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Streaming carry-save accumulator that produces the redundant (sum, carry) vector pair consumed by the team's carry-propagate adder stage. Operands arrive one per beat on a valid/ready stream; each beat is folded into the running total with a 3:2 compressor, with no carry propagation. When a packet's last operand is accepted, the pair is registered for the downstream adder, whose `a + b` result is the packet total modulo 2^BITS.

## Interface
- `BITS`, default 40: operand and vector width.
- `COUNT_W`, default 8: width of `out_count`. Present only with `CSA_ACC_COUNT_EN`.

- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset. One clock. Reset is asynchronous and active-low.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: operand beat accepted when `in_valid && in_ready`.
- `in_data`  in  BITS: operand, unsigned, mod 2^BITS.
- `in_last`  in  1: final operand of the packet.
- `out_valid`  out  1: result pair valid.
- `out_ready`  in  1: downstream accepts the pair.
- `out_sum`  out  BITS: sum vector; feeds adder input `a`.
- `out_carry`  out  BITS: carry vector, already shifted; feeds adder input `b`.
- `out_count`  out  COUNT_W: operands in the packet. `CSA_ACC_COUNT_EN` only.

## Operation
- State:
  - accumulator pair `acc_s`, `acc_c`;
  - output pair `o_s`, `o_c`;
  - `out_valid` flag;
  - with `CSA_ACC_COUNT_EN`, `acc_n` and `o_n`.
- Compression of operand `d` with pair (s, c):
  - s' = s ^ c ^ d;
  - c' = ((s&c) | (s&d) | (c&d)) << 1;
  - bit 0 of c' is 0. The MSB carry-out is discarded, which gives modulo 2^BITS.
- On an accepted non-last beat:
  - (`acc_s`, `acc_c`) <= compress(`acc_s`, `acc_c`, `in_data`).
- On an accepted last beat:
  - (`o_s`, `o_c`) <= compress(`acc_s`, `acc_c`, `in_data`);
  - `acc_s` and `acc_c` <= 0;
  - `out_valid` <= 1.
- Invariant: `out_sum + out_carry` (mod 2^BITS) equals the sum of all operands in the packet (mod 2^BITS).
- A single-operand packet yields `out_sum = in_data` and `out_carry = 0`.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready` and applies to every beat, including non-last beats.
- `out_valid` clears on `out_valid && out_ready`, unless a last beat is accepted in the same cycle. In that case the new pair loads and `out_valid` stays 1, giving back-to-back packets at one result per cycle.
- `out_sum` and `out_carry` hold stable while `out_valid && !out_ready`.
- A beat with `in_valid` low has no effect. `in_data` and `in_last` are don't-care then.

## Timing
- Reset values, asynchronous on `rst_n` low: `acc_*`, `o_*` and `out_count` are 0; `out_valid` is 0.
- While reset is asserted, `in_ready` evaluates to 1, but no beat is accepted.
- Reset mid-packet discards the partial accumulation and any held result. No output is produced for the discarded packet.
- Throughput: one operand per cycle while `in_ready` is high.
- Latency: the pair is visible with `out_valid` = 1 in the cycle after the last beat is accepted.
- Backpressure: while `out_valid && !out_ready`, `in_ready` = 0. The accumulator is frozen, and no input beat of any kind is accepted.

## Configuration
- `CSA_ACC_COUNT_EN` defined:
  - the `COUNT_W` parameter and `out_count` port exist;
  - `acc_n` increments on each accepted beat and saturates at 2^COUNT_W−1;
  - on a last beat, `o_n` <= `acc_n` + 1, saturating, and `acc_n` <= 0;
  - `out_count` = `o_n`, with the same stability rules as `out_sum`.
- `CSA_ACC_COUNT_EN` undefined: no counter logic, no `COUNT_W`, no `out_count` port. The rest of the behaviour is identical.

## Test plan
- **Basic packet.** Reset, then packet 3, 5, 7 (last on 7) with `out_ready` = 1.
  - Expected: `out_valid` for one cycle with `out_sum` = 3, `out_carry` = 12 (total 15).
  - With the macro: `out_count` = 3.
- **Wrap-around.** Packet 0xFF_FFFF_FFFF, 0x1.
  - Expected: `out_sum` = 0xFF_FFFF_FFFE, `out_carry` = 0x2; the adder result is 0.
- **Single operand and back-to-back.** Single-operand packets 0xA then 0xB on consecutive cycles with `out_ready` = 1.
  - Expected: results (0xA, 0) then (0xB, 0) on consecutive cycles.
  - `in_ready` stays 1 throughout.
- **Backpressure.** Hold `out_ready` = 0 after packet 1, 2 completes.
  - Expected: `out_valid` = 1 with `out_sum` + `out_carry` = 3 held stable; `in_ready` = 0.
  - A beat of 9 presented in that window is not accepted.
  - After `out_ready` = 1 for one cycle, the 9 is accepted next and the packet 9 (last) yields a total of 9.
- **Asynchronous reset mid-packet.** Assert `rst_n` = 0 between edges after beats 4, 4 (not last).
  - Expected: all outputs go to 0 immediately.
  - A following packet of 6 (last) yields (6, 0).
- **Counter saturation** (macro on, `COUNT_W` = 2). Packet of five beats of 1.
  - Expected: `out_count` = 3; `out_sum` + `out_carry` = 5.
